// File: rtl/tl_phase_timer.sv
// Phase-duration timer for the highway/farm-road lights: times each green or
// yellow phase and returns a one-cycle time_out pulse to the owning controller.
module tl_phase_timer #(
  parameter int unsigned CLK_DIV    = 50_000_000,
  parameter logic [7:0]  T_GREEN_HW = 8'd25,
  parameter logic [7:0]  T_GREEN_FR = 8'd10,
  parameter logic [7:0]  T_YELLOW   = 8'd3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] state_hw,
  input  logic [1:0] state_fr,
  output logic       time_out_hw,
  output logic       time_out_fr,
  output logic [7:0] sec_left,
  output logic       conflict
);

  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] DIV_M1 = PW'(CLK_DIV - 1);

  // Zero durations would never expire; treat them as one second.
  localparam logic [7:0] DUR_HW_G = (T_GREEN_HW == 8'd0) ? 8'd1 : T_GREEN_HW;
  localparam logic [7:0] DUR_FR_G = (T_GREEN_FR == 8'd0) ? 8'd1 : T_GREEN_FR;
  localparam logic [7:0] DUR_Y    = (T_YELLOW   == 8'd0) ? 8'd1 : T_YELLOW;

  localparam logic [1:0] CODE_G = 2'b01;
  localparam logic [1:0] CODE_Y = 2'b10;

  typedef enum logic [2:0] {
    PH_NONE = 3'd0,
    PH_HW_G = 3'd1,
    PH_HW_Y = 3'd2,
    PH_FR_G = 3'd3,
    PH_FR_Y = 3'd4
  } phase_e;

  phase_e        act, phase_q;
  logic [PW-1:0] presc;
  logic [7:0]    sec_cnt;
  logic [7:0]    dur;
  logic          done;
  logic          hw_on, fr_on, is_hw;

  assign hw_on = (state_hw == CODE_G) || (state_hw == CODE_Y);
  assign fr_on = (state_fr == CODE_G) || (state_fr == CODE_Y);

  // Highway has priority when both roads claim an active phase.
  always_comb begin
    act = PH_NONE;
    if      (state_hw == CODE_G) act = PH_HW_G;
    else if (state_hw == CODE_Y) act = PH_HW_Y;
    else if (state_fr == CODE_G) act = PH_FR_G;
    else if (state_fr == CODE_Y) act = PH_FR_Y;
  end

  always_comb begin
    dur = DUR_Y;
    if      (act == PH_HW_G) dur = DUR_HW_G;
    else if (act == PH_FR_G) dur = DUR_FR_G;
  end

  assign is_hw    = (phase_q == PH_HW_G) || (phase_q == PH_HW_Y);
  assign sec_left = sec_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q     <= PH_NONE;
      presc       <= '0;
      sec_cnt     <= 8'd0;
      done        <= 1'b0;
      time_out_hw <= 1'b0;
      time_out_fr <= 1'b0;
      conflict    <= 1'b0;
    end else begin
      time_out_hw <= 1'b0;
      time_out_fr <= 1'b0;
      phase_q     <= act;
      if (hw_on && fr_on) conflict <= 1'b1;

      if (act == PH_NONE) begin
        presc   <= '0;
        sec_cnt <= 8'd0;
        done    <= 1'b0;
      end else if (act != phase_q) begin
        // New or aborted phase: reload without pulsing for the old one.
        presc   <= '0;
        sec_cnt <= dur;
        done    <= 1'b0;
      end else if (!done) begin
        if (presc == DIV_M1) begin
          presc <= '0;
          if (sec_cnt > 8'd1) begin
            sec_cnt <= sec_cnt - 8'd1;
          end else begin
            sec_cnt     <= 8'd0;
            done        <= 1'b1;
            time_out_hw <= is_hw;
            time_out_fr <= !is_hw;
          end
        end else begin
          presc <= presc + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tl_phase_timer.sv
// Randomized and directed bench for tl_phase_timer against an elapsed-time
// model of phase durations.
module tb_tl_phase_timer;
  localparam int DIV = 4;
  localparam int TGH = 3;
  localparam int TGF = 2;
  localparam int TY  = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] state_hw = 2'b00;
  logic [1:0] state_fr = 2'b00;
  logic       time_out_hw, time_out_fr, conflict;
  logic [7:0] sec_left;

  always #5 clk = ~clk;

  tl_phase_timer #(
    .CLK_DIV(DIV), .T_GREEN_HW(8'(TGH)), .T_GREEN_FR(8'(TGF)), .T_YELLOW(8'(TY))
  ) dut (
    .clk(clk), .rst_n(rst_n), .state_hw(state_hw), .state_fr(state_fr),
    .time_out_hw(time_out_hw), .time_out_fr(time_out_fr),
    .sec_left(sec_left), .conflict(conflict)
  );

  int checks = 0, fails = 0, cyc = 0, npulse = 0;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // 0 none, 1 hw green, 2 hw yellow, 3 fr green, 4 fr yellow
  function automatic int act_of(input logic [1:0] h, input logic [1:0] f);
    if (h == 2'b01) return 1;
    if (h == 2'b10) return 2;
    if (f == 2'b01) return 3;
    if (f == 2'b10) return 4;
    return 0;
  endfunction

  function automatic int dur_of(input int a);
    if (a == 1) return TGH;
    if (a == 3) return TGF;
    return TY;
  endfunction

  // Model: remember the edge a phase started; outputs follow from elapsed edges.
  int m_prev = 0, m_start = 0, m_t = 0, m_a = 0, m_el = 0, e_sec = 0;
  bit m_conf = 0, e_hw = 0, e_fr = 0;

  always begin
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      m_prev = 0; m_conf = 0; e_sec = 0; e_hw = 0; e_fr = 0;
    end else begin
      m_a = act_of(state_hw, state_fr);
      if ((state_hw == 2'b01 || state_hw == 2'b10) &&
          (state_fr == 2'b01 || state_fr == 2'b10)) m_conf = 1;
      if (m_a != 0 && m_a != m_prev) begin
        m_start = cyc;
        m_t = dur_of(m_a);
      end
      m_prev = m_a;
      if (m_a == 0) begin
        e_sec = 0; e_hw = 0; e_fr = 0;
      end else begin
        m_el  = cyc - m_start;
        e_sec = m_t - m_el / DIV;
        if (e_sec < 0) e_sec = 0;
        e_hw = (m_el == m_t * DIV) && (m_a <= 2);
        e_fr = (m_el == m_t * DIV) && (m_a >= 3);
      end
    end
    #1;
    chk("sec_left", sec_left, e_sec);
    chk("time_out_hw", time_out_hw, e_hw);
    chk("time_out_fr", time_out_fr, e_fr);
    chk("conflict", conflict, m_conf);
    if (time_out_hw || time_out_fr) npulse++;
  end

  // k = index of the pulse edge, counting the first edge after the call as 0.
  task automatic wait_pulse(input string nm, output int k);
    k = -1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #2;
      if (time_out_hw || time_out_fr) begin
        k = i;
        break;
      end
    end
    if (k < 0) begin
      checks++; fails++;
      $display("FAIL %s: no pulse within 200 cycles", nm);
    end
  endtask

  int k, pk, pcnt, fcnt, n0;

  initial begin
    repeat (3) @(negedge clk);
    chk("reset sec_left", sec_left, 0);
    chk("reset time_out_hw", time_out_hw, 0);
    chk("reset time_out_fr", time_out_fr, 0);
    chk("reset conflict", conflict, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Highway green from edge E
    state_hw = 2'b01; state_fr = 2'b00;
    pk = -1; pcnt = 0; fcnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #2;
      if (i == 1) chk("hwg sec@E+1", sec_left, 3);
      if (i == 4) chk("hwg sec@E+4", sec_left, 2);
      if (i == 8) chk("hwg sec@E+8", sec_left, 1);
      if (i == 12) chk("hwg sec@E+12", sec_left, 0);
      if (time_out_hw) begin pk = i; pcnt++; end
      if (time_out_fr) fcnt++;
    end
    chk("hwg pulse edge", pk, 12);
    chk("hwg pulse count", pcnt, 1);
    chk("hwg fr pulses", fcnt, 0);

    // Full cycle driven by a controller reacting to each pulse
    @(negedge clk); state_hw = 2'b00;
    @(negedge clk);
    n0 = npulse;
    @(negedge clk); state_hw = 2'b01;
    wait_pulse("cycle hw_g", k); chk("cycle hw_g edge", k, 12); chk("cycle hw_g owner", time_out_hw, 1);
    @(negedge clk); state_hw = 2'b10;
    wait_pulse("cycle hw_y", k); chk("cycle hw_y edge", k, 8); chk("cycle hw_y owner", time_out_hw, 1);
    @(negedge clk); state_hw = 2'b00; state_fr = 2'b01;
    wait_pulse("cycle fr_g", k); chk("cycle fr_g edge", k, 8); chk("cycle fr_g owner", time_out_fr, 1);
    @(negedge clk); state_fr = 2'b10;
    wait_pulse("cycle fr_y", k); chk("cycle fr_y edge", k, 8); chk("cycle fr_y owner", time_out_fr, 1);
    @(negedge clk); state_fr = 2'b00;
    repeat (5) @(negedge clk);
    chk("cycle pulse total", npulse - n0, 4);
    chk("cycle no conflict", conflict, 0);

    // Hold green long after expiry
    state_hw = 2'b01;
    wait_pulse("hold", k); chk("hold first edge", k, 12);
    n0 = npulse;
    repeat (40) begin @(posedge clk); #2; end
    chk("hold extra pulses", npulse - n0, 0);
    chk("hold sec_left", sec_left, 0);

    // Abort green with yellow at E+5
    @(negedge clk); state_hw = 2'b00;
    @(negedge clk); state_hw = 2'b01;
    n0 = npulse;
    repeat (5) @(posedge clk);
    @(negedge clk); state_hw = 2'b10;
    @(posedge clk); #2;
    chk("abort reload", sec_left, 2);
    wait_pulse("abort", k);
    chk("abort pulse edge", k + 1, 8);
    chk("abort pulse count", npulse - n0, 1);

    // Conflict, then reset mid-count
    @(negedge clk); state_hw = 2'b00;
    @(negedge clk); state_hw = 2'b01; state_fr = 2'b10;
    @(posedge clk); #2;
    chk("conf set", conflict, 1);
    chk("conf hw timed", sec_left, 3);
    repeat (4) begin @(posedge clk); #2; end
    chk("conf sticky", conflict, 1);
    chk("conf sec mid", sec_left, 2);
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("arst sec_left", sec_left, 0);
    chk("arst conflict", conflict, 0);
    chk("arst hw", time_out_hw, 0);
    chk("arst fr", time_out_fr, 0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #2;
    chk("rst retime sec", sec_left, 3);
    wait_pulse("rst retime", k);
    chk("rst retime edge", k + 1, 12);
    chk("rst retime owner", time_out_hw, 1);

    // Random phase codes with occasional resets
    @(negedge clk); state_hw = 2'b00; state_fr = 2'b00;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 19) == 0) state_hw = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) state_fr = 2'($urandom_range(0, 3));
      rst_n = ($urandom_range(0, 499) != 0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
